// File: rtl/l0_feeder.sv
// rtl/l0_feeder.sv - weight/activation sequencer feeding L0 and driving corelet inst
//
// Purpose: one start pulse runs a full pass: stream w_len weight words from
// SRAM into L0, hold inst=01 while the MAC array loads kernels, stream x_len
// activation words into L0, hold inst=10 while it executes, then pulse done.
// SRAM read latency and L0 backpressure are absorbed by a 2-entry skid buffer.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   start                  begin a pass (sampled only in IDLE)
//   w_base/w_len           first SRAM address / count of weight words
//   x_base/x_len           first SRAM address / count of activation words
//   sram_cen/wen/addr      SRAM read port (active-low enables, wen tied high)
//   sram_q                 SRAM read data, valid the cycle after a read
//   data_to_l0, l0_wr      L0 write port
//   l0_full                L0 full, blocks writes in the same cycle
//   l0_rd                  L0 read strobe
//   inst                   {execute, kernel loading}
//   busy, done, err        status: not idle / end-of-pass pulse / rejected start
module l0_feeder #(
  parameter int bw        = 4,
  parameter int row       = 8,
  parameter int addr_bw   = 11,
  parameter int len_bw    = 7,
  parameter int L0_DEPTH  = 64,
  parameter int KER_TAIL  = 8,
  parameter int EXEC_TAIL = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [addr_bw-1:0]  w_base,
  input  logic [len_bw-1:0]   w_len,
  input  logic [addr_bw-1:0]  x_base,
  input  logic [len_bw-1:0]   x_len,
  output logic                sram_cen,
  output logic                sram_wen,
  output logic [addr_bw-1:0]  sram_addr,
  input  logic [bw*row-1:0]   sram_q,
  output logic [bw*row-1:0]   data_to_l0,
  output logic                l0_wr,
  input  logic                l0_full,
  output logic                l0_rd,
  output logic [1:0]          inst,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int W        = bw * row;
  localparam int MAX_TAIL = (KER_TAIL > EXEC_TAIL) ? KER_TAIL : EXEC_TAIL;
  localparam int PH_BW    = $clog2(L0_DEPTH + MAX_TAIL + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_KERN, S_LOAD_X, S_EXEC, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [addr_bw-1:0]   w_base_q, w_base_d, x_base_q, x_base_d;
  logic [len_bw-1:0]    w_len_q, w_len_d, x_len_q, x_len_d;
  logic [len_bw-1:0]    rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [PH_BW-1:0]     ph_cnt_q, ph_cnt_d;
  logic [addr_bw-1:0]   addr_q, addr_d;
  logic [W-1:0]         buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]           occ_q, occ_d;
  logic                 inflight_q, inflight_d;
  logic [1:0]           inst_q, inst_d;
  logic                 l0_rd_q, l0_rd_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic                 is_load, pop, issue, start_ok;
  logic [2:0]           pend;
  logic [addr_bw-1:0]   cur_base, rd_addr;
  logic [len_bw-1:0]    cur_len;
  logic [PH_BW-1:0]     ker_last, exec_last, rd_len_d;

  // Read issue and L0 write are resolved in the current cycle from registered
  // buffer state and l0_full, so a 2-entry buffer sustains one word per cycle
  // while never overflowing under backpressure.
  assign is_load   = (state_q == S_LOAD_W) || (state_q == S_LOAD_X);
  assign cur_base  = (state_q == S_LOAD_X) ? x_base_q : w_base_q;
  assign cur_len   = (state_q == S_LOAD_X || state_q == S_EXEC) ? x_len_q : w_len_q;
  assign pop       = (occ_q != 2'd0) && !l0_full;
  assign pend      = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue     = is_load && (rd_cnt_q != cur_len) && (pend <= 3'd1);
  assign rd_addr   = cur_base + addr_bw'(rd_cnt_q);
  assign start_ok  = (w_len != '0) && (w_len <= len_bw'(L0_DEPTH)) &&
                     (x_len != '0) && (x_len <= len_bw'(L0_DEPTH));
  assign ker_last  = PH_BW'(w_len_q) + PH_BW'(KER_TAIL - 1);
  assign exec_last = PH_BW'(x_len_q) + PH_BW'(EXEC_TAIL - 1);

  assign sram_cen   = !issue;
  assign sram_wen   = 1'b1;
  assign sram_addr  = issue ? rd_addr : addr_q;
  assign data_to_l0 = buf0_q;
  assign l0_wr      = pop;
  assign l0_rd      = l0_rd_q;
  assign inst       = inst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

  always_comb begin
    state_d    = state_q;
    w_base_d   = w_base_q;
    w_len_d    = w_len_q;
    x_base_d   = x_base_q;
    x_len_d    = x_len_q;
    ph_cnt_d   = ph_cnt_q;
    err_d      = 1'b0;
    inflight_d = issue;
    addr_d     = issue ? rd_addr : addr_q;
    rd_cnt_d   = rd_cnt_q + len_bw'(issue);
    wr_cnt_d   = wr_cnt_q + len_bw'(pop);

    // Skid buffer: pop shifts the head out, then the returning SRAM word
    // lands in the first free slot.
    occ_d  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (pop) begin
      buf0_d = buf1_q;
      occ_d  = occ_q - 2'd1;
    end
    if (inflight_q) begin
      if (occ_d == 2'd0) buf0_d = sram_q;
      else               buf1_d = sram_q;
      occ_d = occ_d + 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_ok) begin
            w_base_d = w_base;
            w_len_d  = w_len;
            x_base_d = x_base;
            x_len_d  = x_len;
            rd_cnt_d = '0;
            wr_cnt_d = '0;
            state_d  = S_LOAD_W;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD_W, S_LOAD_X: begin
        // All reads have returned once the last word is written.
        if (wr_cnt_d == cur_len) begin
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          ph_cnt_d = '0;
          state_d  = (state_q == S_LOAD_W) ? S_KERN : S_EXEC;
        end
      end
      S_KERN: begin
        ph_cnt_d = ph_cnt_q + PH_BW'(1);
        if (ph_cnt_q == ker_last) begin
          ph_cnt_d = '0;
          state_d  = S_LOAD_X;
        end
      end
      S_EXEC: begin
        ph_cnt_d = ph_cnt_q + PH_BW'(1);
        if (ph_cnt_q == exec_last) begin
          ph_cnt_d = '0;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state.
    rd_len_d = (state_d == S_EXEC) ? PH_BW'(x_len_q) : PH_BW'(w_len_q);
    inst_d   = (state_d == S_KERN) ? 2'b01 : (state_d == S_EXEC) ? 2'b10 : 2'b00;
    l0_rd_d  = ((state_d == S_KERN) || (state_d == S_EXEC)) && (ph_cnt_d < rd_len_d);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      w_base_q   <= '0;
      w_len_q    <= '0;
      x_base_q   <= '0;
      x_len_q    <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      ph_cnt_q   <= '0;
      addr_q     <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      inst_q     <= 2'b00;
      l0_rd_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_base_q   <= w_base_d;
      w_len_q    <= w_len_d;
      x_base_q   <= x_base_d;
      x_len_q    <= x_len_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      ph_cnt_q   <= ph_cnt_d;
      addr_q     <= addr_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      inst_q     <= inst_d;
      l0_rd_q    <= l0_rd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_l0_feeder.sv
// tb/tb_l0_feeder.sv - self-checking bench for l0_feeder
module tb_l0_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] w_base, x_base;
  logic [6:0]  w_len, x_len;
  logic        sram_cen, sram_wen;
  logic [10:0] sram_addr;
  logic [31:0] sram_q;
  logic [31:0] data_to_l0;
  logic        l0_wr, l0_full, l0_rd;
  logic [1:0]  inst;
  logic        busy, done, err;

  l0_feeder dut (
    .clk(clk), .reset(reset), .start(start),
    .w_base(w_base), .w_len(w_len), .x_base(x_base), .x_len(x_len),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_q(sram_q),
    .data_to_l0(data_to_l0), .l0_wr(l0_wr), .l0_full(l0_full), .l0_rd(l0_rd),
    .inst(inst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_f(input logic [10:0] a);
    return {a[2:0] ^ 3'h5, a, 7'h2a ^ a[6:0], ~a};
  endfunction

  always @(posedge clk) if (!sram_cen) sram_q <= mem_f(sram_addr);

  // Monitor
  logic [10:0] rd_addrs[$];
  logic [31:0] wr_data[$];
  int n_rd, n_wr, wr_full, over2, wen_bad, kern_rd, exec_rd, stray_rd;
  int kern_cyc, exec_cyc, done_n, done_cyc, err_n, err_cyc, busy_n, first_rd, first_wr;

  task automatic clear_mon();
    rd_addrs.delete(); wr_data.delete();
    n_rd = 0; n_wr = 0; wr_full = 0; over2 = 0; wen_bad = 0;
    kern_rd = 0; exec_rd = 0; stray_rd = 0; kern_cyc = 0; exec_cyc = 0;
    done_n = 0; done_cyc = -1; err_n = 0; err_cyc = -1; busy_n = 0;
    first_rd = -1; first_wr = -1;
  endtask

  always @(negedge clk) begin
    if (n_rd - n_wr > 2) over2++;
    if (sram_wen !== 1'b1) wen_bad++;
    if (!sram_cen) begin
      rd_addrs.push_back(sram_addr); n_rd++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (l0_wr) begin
      if (l0_full) wr_full++;
      wr_data.push_back(data_to_l0); n_wr++;
      if (first_wr < 0) first_wr = cyc;
    end
    if (l0_rd) begin
      if (inst == 2'b01) kern_rd++;
      else if (inst == 2'b10) exec_rd++;
      else stray_rd++;
    end
    if (inst == 2'b01) kern_cyc++;
    if (inst == 2'b10) exec_cyc++;
    if (inst == 2'b11) stray_rd++;
    if (done) begin done_n++; done_cyc = cyc; end
    if (err) begin err_n++; err_cyc = cyc; end
    if (busy) busy_n++;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic check_reset(input string nm);
    check({nm, ".sram_cen"}, 64'(sram_cen), 1);
    check({nm, ".sram_wen"}, 64'(sram_wen), 1);
    check({nm, ".sram_addr"}, 64'(sram_addr), 0);
    check({nm, ".data_to_l0"}, 64'(data_to_l0), 0);
    check({nm, ".l0_wr"}, 64'(l0_wr), 0);
    check({nm, ".l0_rd"}, 64'(l0_rd), 0);
    check({nm, ".inst"}, 64'(inst), 0);
    check({nm, ".busy"}, 64'(busy), 0);
    check({nm, ".done"}, 64'(done), 0);
    check({nm, ".err"}, 64'(err), 0);
  endtask

  typedef struct {
    logic [10:0] w_base;
    logic [6:0]  w_len;
    logic [10:0] x_base;
    logic [6:0]  x_len;
    int          full_off;   // first cycle (relative to start) with l0_full=1
    int          full_n;     // number of full cycles
    bit          mid_start;  // extra start pulses during KERN and EXEC
    bit          exp_err;
    int          exp_done;   // done cycle relative to start cycle
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input string nm);
    int s;
    int tmo;
    int bad;
    int nexp;
    logic [10:0] ea[$];
    clear_mon();
    @(posedge clk); #1;
    w_base = v.w_base; w_len = v.w_len; x_base = v.x_base; x_len = v.x_len;
    start = 1'b1; s = cyc;
    tmo = 1;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      start   = v.mid_start && (cyc == s + 15 || cyc == s + 50);
      l0_full = (v.full_n > 0) && (cyc >= s + v.full_off) && (cyc < s + v.full_off + v.full_n);
      if (v.exp_err ? (cyc >= s + 6) : (done_n > 0 && cyc >= done_cyc + 2)) begin
        tmo = 0;
        break;
      end
    end
    start = 1'b0; l0_full = 1'b0;
    check({nm, ".timeout"}, 64'(tmo), 0);
    check({nm, ".wen"}, 64'(wen_bad), 0);
    if (v.exp_err) begin
      check({nm, ".err_pulses"}, 64'(err_n), 1);
      check({nm, ".err_cycle"}, 64'(err_cyc - s), 1);
      check({nm, ".busy_cycles"}, 64'(busy_n), 0);
      check({nm, ".sram_reads"}, 64'(n_rd), 0);
      check({nm, ".l0_writes"}, 64'(n_wr), 0);
      check({nm, ".done_pulses"}, 64'(done_n), 0);
    end else begin
      for (int k = 0; k < int'(v.w_len); k++) ea.push_back(v.w_base + 11'(k));
      for (int k = 0; k < int'(v.x_len); k++) ea.push_back(v.x_base + 11'(k));
      nexp = ea.size();
      check({nm, ".done_pulses"}, 64'(done_n), 1);
      check({nm, ".done_cycle"}, 64'(done_cyc - s), 64'(v.exp_done));
      check({nm, ".busy_cycles"}, 64'(busy_n), 64'(v.exp_done));
      check({nm, ".err_pulses"}, 64'(err_n), 0);
      check({nm, ".first_read"}, 64'(first_rd - s), 1);
      check({nm, ".first_write"}, 64'(first_wr - s), 3);
      check({nm, ".sram_reads"}, 64'(rd_addrs.size()), 64'(nexp));
      bad = 0;
      for (int k = 0; k < nexp && k < rd_addrs.size(); k++) if (rd_addrs[k] !== ea[k]) bad++;
      check({nm, ".addr_seq_errs"}, 64'(bad), 0);
      check({nm, ".l0_writes"}, 64'(wr_data.size()), 64'(nexp));
      bad = 0;
      for (int k = 0; k < nexp && k < wr_data.size(); k++) if (wr_data[k] !== mem_f(ea[k])) bad++;
      check({nm, ".data_seq_errs"}, 64'(bad), 0);
      check({nm, ".kern_l0_rd"}, 64'(kern_rd), 64'(v.w_len));
      check({nm, ".exec_l0_rd"}, 64'(exec_rd), 64'(v.x_len));
      check({nm, ".stray_rd_inst"}, 64'(stray_rd), 0);
      check({nm, ".kern_cycles"}, 64'(kern_cyc), 64'(int'(v.w_len) + 8));
      check({nm, ".exec_cycles"}, 64'(exec_cyc), 64'(int'(v.x_len) + 16));
      check({nm, ".wr_while_full"}, 64'(wr_full), 0);
      check({nm, ".over_two_buffered"}, 64'(over2), 0);
    end
  endtask

  initial begin
    int s;
    vecs[0] = '{11'h010, 7'd8,  11'h100, 7'd16, 0,  0, 1'b0, 1'b0, 77};
    vecs[1] = '{11'h010, 7'd8,  11'h100, 7'd16, 32, 5, 1'b0, 1'b0, 82};
    vecs[2] = '{11'h7FE, 7'd3,  11'h000, 7'd1,  0,  0, 1'b0, 1'b0, 37};
    vecs[3] = '{11'h200, 7'd64, 11'h7E0, 7'd64, 0,  0, 1'b0, 1'b0, 285};
    vecs[4] = '{11'h010, 7'd0,  11'h100, 7'd16, 0,  0, 1'b0, 1'b1, 0};
    vecs[5] = '{11'h010, 7'd8,  11'h100, 7'd65, 0,  0, 1'b0, 1'b1, 0};
    vecs[6] = '{11'h030, 7'd8,  11'h140, 7'd16, 0,  0, 1'b1, 1'b0, 77};

    clear_mon();
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start   = 1'($urandom);
      l0_full = 1'($urandom);
      w_base  = 11'($urandom); w_len = 7'($urandom);
      x_base  = 11'($urandom); x_len = 7'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0; l0_full = 1'b0; reset = 1'b0;
    @(negedge clk);
    check_reset("reset");

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in LOAD_X with a read in flight, then a clean pass.
    clear_mon();
    @(posedge clk); #1;
    w_base = 11'h010; w_len = 7'd8; x_base = 11'h100; x_len = 7'd16;
    start = 1'b1; s = cyc;
    while (cyc < s + 30) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("midrst.reads_before_reset", 64'(rd_addrs.size()), 11);
    check("midrst.read_in_flight", 64'(sram_cen), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset("midrst");
    run_vec(vecs[0], "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
